mv_ref_addr_gen: RTL and testbench
==================================

// Module: mv_ref_addr_gen
// PURPOSE
//  Downstream consumer of the stored 16-bit motion vector (MV) register.
//  Turns {MV, current block position} into the raster sequence of reference-frame
//  pixel addresses for one BLOCK_SIZE x BLOCK_SIZE reference block.
//  Clamps coordinates to the frame edge (edge-pixel padding).
//  Feeds the reference-frame memory read port through a valid/ready handshake.
// PARAMETERS
//  BLOCK_SIZE  8   block edge in pixels; power of 2, >=2
//  FRAME_W     64  frame width in pixels; power of 2
//  FRAME_H     64  frame height in pixels; power of 2
//  ADDR_W      12  address width = log2(FRAME_W*FRAME_H)
//  COORD_W     6   pixel coordinate width = log2(max(FRAME_W,FRAME_H))
// PORTS
//  CLK          in   1        clock, rising edge
//  RST_ASYNC_N  in   1        reset, asynchronous, active-low
//  START        in   1        request one block; accepted only in IDLE
//  MV_IN        in   16       signed MV: [15:8] horizontal, [7:0] vertical, integer-pel, two's complement
//  BLK_X        in   COORD_W  current block top-left column
//  BLK_Y        in   COORD_W  current block top-left row
//  ADDR_OUT     out  ADDR_W   reference pixel address = y*FRAME_W + x
//  ADDR_VALID   out  1        ADDR_OUT valid
//  ADDR_READY   in   1        consumer accepts ADDR_OUT this cycle
//  BUSY         out  1        high in every state except IDLE
//  DONE         out  1        one-cycle pulse after the last address is accepted
// BEHAVIOUR
//  Reset: clock CLK; reset RST_ASYNC_N, asynchronous, active-low.
//   Under reset: state=IDLE; ADDR_OUT=0, ADDR_VALID=0, BUSY=0, DONE=0; counters=0.
//  FSM states: IDLE -> CALC -> EMIT -> FIN -> IDLE.
//   IDLE: START=1 registers MV_IN, BLK_X and BLK_Y, then goes to CALC.
//   CALC: one cycle. Computes base bx = BLK_X + mv_h and by = BLK_Y + mv_v.
//    Signed, width COORD_W+3; no overflow possible.
//   EMIT: ADDR_VALID=1. A transfer occurs on ADDR_VALID & ADDR_READY.
//    After each transfer: col++; when col wraps from BLOCK_SIZE-1, row++.
//    Transfer at row=col=BLOCK_SIZE-1 -> FIN.
//   FIN: DONE=1 for exactly one cycle, ADDR_VALID=0, then IDLE.
//  Latency: START at cycle t -> first ADDR_VALID at t+2.
//   With ADDR_READY held high: one address per cycle, BLOCK_SIZE^2 addresses.
//   DONE at t+2+BLOCK_SIZE^2.
//  Address computation:
//   x = clamp(bx+col, 0, FRAME_W-1); y = clamp(by+row, 0, FRAME_H-1).
//   ADDR_OUT = {y, x[log2(FRAME_W)-1:0]}; no multiplier.
//  ADDR_OUT is registered.
//   Stable while ADDR_VALID & !ADDR_READY; no skipped or repeated addresses.
//  START outside IDLE is ignored. MV_IN, BLK_X and BLK_Y may change after acceptance.
//  ADDR_READY outside EMIT is ignored.
//  RST_ASYNC_N low mid-block aborts immediately: outputs go to reset values, no DONE.
//   After release, the next START behaves normally.
//  MV extremes (-128 and +127) are legal. Clamping absorbs any out-of-frame coordinate.
// STRUCTURE
//  Shared include mv_defs.vh holds:
//   MV field bounds (MV_H_MSB=15, MV_H_LSB=8, MV_V_MSB=7, MV_V_LSB=0) and MV_W=16.
//   State encodings (IDLE=2'd0, CALC=2'd1, EMIT=2'd2, FIN=2'd3).
//  Sub-module coord_clamp: combinational signed saturate to [0, LIMIT-1].
//   Instantiated once for x and once for y.
//  Top level holds the FSM, the row/col counters and the output register.
// TESTING  (FRAME 64x64, BLOCK_SIZE 8)
//  1. MV=0x0000, BLK=(8,8), READY=1 -> 64 addresses from 520 to 975 in raster order.
//     First ADDR_VALID at t+2; DONE pulses once.
//  2. MV=0x02FF (h=+2, v=-1), BLK=(8,8) -> first addr 458 (y7,x10); last addr 913 (y14,x17).
//  3. MV=0x8000 (h=-128), BLK=(0,0) -> every x clamps to 0.
//     Addresses 0,0,...,64,64,...,448; each row value repeated 8 times.
//  4. MV=0x0707, BLK=(56,56) -> last 8 addresses all 4095 (bottom-right clamp); DONE once.
//  5. ADDR_READY low for 3 cycles mid-row -> ADDR_OUT held constant.
//     Exactly 64 transfers total; the address sequence is identical to the no-stall run.
//  6. START pulsed while BUSY -> ignored.
//     RST_ASYNC_N low during EMIT -> outputs 0 at once, no DONE.
//     A fresh START after release reproduces scenario 1.

Source files
------------

// File: rtl/mv_ref_addr_gen_pkg.sv
// mv_ref_addr_gen_pkg: MV field bounds and FSM state encodings shared by the reference address generator
package mv_ref_addr_gen_pkg;
  localparam int MV_W     = 16;
  localparam int MV_H_MSB = 15;
  localparam int MV_H_LSB = 8;
  localparam int MV_V_MSB = 7;
  localparam int MV_V_LSB = 0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_t;
endpackage

// File: rtl/mv_ref_addr_gen_coord_clamp.sv
// coord_clamp: combinational signed saturate of a coordinate to [0, LIMIT-1]
module coord_clamp #(
  parameter int W     = 9,
  parameter int LIMIT = 64,
  parameter int OW    = 6
) (
  input  logic signed [W-1:0]  v,
  output logic        [OW-1:0] q
);
  localparam logic signed [W-1:0] MAXV = W'(LIMIT - 1);
  always_comb q = v[W-1] ? '0 : (v > MAXV) ? OW'(LIMIT - 1) : v[OW-1:0];
endmodule

// File: rtl/mv_ref_addr_gen.sv
// mv_ref_addr_gen: emits the clamped raster address sequence of one MV-displaced reference block
module mv_ref_addr_gen
  import mv_ref_addr_gen_pkg::*;
#(
  parameter int BLOCK_SIZE = 8,
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 64,
  parameter int ADDR_W     = 12,
  parameter int COORD_W    = 6
) (
  input  logic               CLK,
  input  logic               RST_ASYNC_N,
  input  logic               START,
  input  logic [MV_W-1:0]    MV_IN,
  input  logic [COORD_W-1:0] BLK_X,
  input  logic [COORD_W-1:0] BLK_Y,
  output logic [ADDR_W-1:0]  ADDR_OUT,
  output logic               ADDR_VALID,
  input  logic               ADDR_READY,
  output logic               BUSY,
  output logic               DONE
);
  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);
  localparam int BW = COORD_W + 3;
  localparam int CW = $clog2(BLOCK_SIZE);
  state_t state, state_nxt;
  logic [MV_W-1:0] mv;
  logic [COORD_W-1:0] blk_x, blk_y;
  logic signed [BW-1:0] bx, by, bx_c, by_c, base_x, base_y, px, py;
  logic [CW-1:0] col, row, col_nxt, row_nxt;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic fire, last;
  always_comb begin
    bx_c   = BW'(signed'({1'b0, blk_x})) + BW'(signed'(mv[MV_H_MSB:MV_H_LSB]));
    by_c   = BW'(signed'({1'b0, blk_y})) + BW'(signed'(mv[MV_V_MSB:MV_V_LSB]));
    base_x = (state == CALC) ? bx_c : bx;
    base_y = (state == CALC) ? by_c : by;
    fire   = (state == EMIT) && ADDR_READY;
    last   = &{row, col};
    col_nxt = (state == EMIT) ? col + 1'b1 : '0;
    row_nxt = (state == EMIT) ? row + CW'(&col) : '0;
    px = base_x + signed'(BW'(col_nxt));
    py = base_y + signed'(BW'(row_nxt));
  end
  // address for the position the counters move to, so ADDR_OUT can be registered
  coord_clamp #(.W(BW), .LIMIT(FRAME_W), .OW(XW)) u_clamp_x (.v(px), .q(cx));
  coord_clamp #(.W(BW), .LIMIT(FRAME_H), .OW(YW)) u_clamp_y (.v(py), .q(cy));
  always_comb
    state_nxt = (state == IDLE) ? (START ? CALC : IDLE) :
                (state == CALC) ? EMIT :
                (state == EMIT) ? ((fire && last) ? FIN : EMIT) : IDLE;
  always_ff @(posedge CLK or negedge RST_ASYNC_N)
    if (!RST_ASYNC_N) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge CLK or negedge RST_ASYNC_N)
    if (!RST_ASYNC_N) begin
      mv       <= '0;
      blk_x    <= '0;
      blk_y    <= '0;
      bx       <= '0;
      by       <= '0;
      col      <= '0;
      row      <= '0;
      ADDR_OUT <= '0;
    end else begin
      if (state == IDLE && START) begin
        mv    <= MV_IN;
        blk_x <= BLK_X;
        blk_y <= BLK_Y;
      end
      if (state == CALC) begin
        bx <= bx_c;
        by <= by_c;
      end
      if (fire) begin
        col <= col_nxt;
        row <= row_nxt;
      end
      if (state == CALC || (fire && !last)) ADDR_OUT <= ADDR_W'({cy, cx});
    end
  assign ADDR_VALID = (state == EMIT);
  assign BUSY       = (state != IDLE);
  assign DONE       = (state == FIN);
endmodule

// File: tb/tb_mv_ref_addr_gen.sv
// tb_mv_ref_addr_gen: random and directed blocks checked against an arithmetic reference model
module tb_mv_ref_addr_gen;
  logic        CLK, RST_ASYNC_N, START, ADDR_READY;
  logic [15:0] MV_IN;
  logic [5:0]  BLK_X, BLK_Y;
  logic [11:0] ADDR_OUT;
  logic        ADDR_VALID, BUSY, DONE;
  int checks = 0, fails = 0, xfers = 0, dones = 0;
  logic [11:0] exp_q[$], got[$], mdl[$], ref1[$];
  logic        prev_stall = 0;
  logic [11:0] prev_addr = 0;
  mv_ref_addr_gen dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START), .MV_IN(MV_IN),
    .BLK_X(BLK_X), .BLK_Y(BLK_Y), .ADDR_OUT(ADDR_OUT), .ADDR_VALID(ADDR_VALID),
    .ADDR_READY(ADDR_READY), .BUSY(BUSY), .DONE(DONE)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction
  // reference: every pixel of the displaced block, clamped, in raster order
  function automatic void model(input logic [15:0] mv, input int bx, input int by);
    int h, v;
    h = int'($signed(mv[15:8]));
    v = int'($signed(mv[7:0]));
    mdl.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mdl.push_back(12'(clampi(by + v + r, 63) * 64 + clampi(bx + h + c, 63)));
  endfunction
  always @(negedge CLK) begin
    if (RST_ASYNC_N) begin
      if (prev_stall) check("hold_while_stalled", int'(ADDR_OUT), int'(prev_addr));
      if (ADDR_VALID && ADDR_READY) begin
        xfers++;
        got.push_back(ADDR_OUT);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_transfer: got addr %0d, expected no transfer", ADDR_OUT);
        end else check("addr_seq", int'(ADDR_OUT), int'(exp_q.pop_front()));
      end
      if (DONE) begin
        dones++;
        check("done_with_all_sent", exp_q.size(), 0);
      end
      prev_stall = ADDR_VALID && !ADDR_READY;
      prev_addr  = ADDR_OUT;
    end else prev_stall = 0;
  end
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask
  // mode: 0 ready held, 1 random ready, 2 three-cycle stall, 3 START while busy, 4 reset abort
  task automatic run_block(input logic [15:0] mv, input logic [5:0] bx, input logic [5:0] by,
                           input int mode, input int exp_n);
    int n, d0;
    model(mv, int'(bx), int'(by));
    foreach (mdl[i]) exp_q.push_back(mdl[i]);
    got.delete();
    xfers = 0;
    d0 = dones;
    START = 1; MV_IN = mv; BLK_X = bx; BLK_Y = by; ADDR_READY = 1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        check("calc_no_valid", int'(ADDR_VALID), 0);
        check("calc_busy", int'(BUSY), 1);
        MV_IN = 16'($urandom); BLK_X = 6'($urandom); BLK_Y = 6'($urandom);
      end
      if (n == 2) check("first_valid_t2", int'(ADDR_VALID), 1);
      START = (mode == 3 && n == 10);
      ADDR_READY = (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 2) ? !(n >= 6 && n <= 8) : 1'b1;
      if (mode == 4 && n == 20) begin
        RST_ASYNC_N = 0;
        #1;
        check("abort_valid", int'(ADDR_VALID), 0);
        check("abort_addr", int'(ADDR_OUT), 0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        exp_q.delete();
        repeat (3) tick();
        check("abort_no_done", dones - d0, 0);
        RST_ASYNC_N = 1;
        tick();
        return;
      end
    end while (!DONE && n < 400);
    check("done_seen", int'(DONE), 1);
    check("fin_no_valid", int'(ADDR_VALID), 0);
    if (exp_n >= 0) check("done_latency", n, exp_n);
    tick();
    check("done_one_cycle", int'(DONE), 0);
    check("idle_not_busy", int'(BUSY), 0);
    check("transfer_count", xfers, 64);
    check("done_count", dones - d0, 1);
    check("model_drained", exp_q.size(), 0);
  endtask
  initial begin
    int mism;
    RST_ASYNC_N = 0; START = 0; ADDR_READY = 0; MV_IN = 0; BLK_X = 0; BLK_Y = 0;
    #3;
    check("rst_addr", int'(ADDR_OUT), 0);
    check("rst_valid", int'(ADDR_VALID), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    repeat (2) tick();
    RST_ASYNC_N = 1;
    tick();
    run_block(16'h0000, 6'd8, 6'd8, 0, 66);
    check("model_s1_first", int'(mdl[0]), 520);
    check("s1_first", int'(got[0]), 520);
    check("s1_r1c1", int'(got[9]), 585);
    check("s1_last", int'(got[63]), 975);
    ref1 = got;
    run_block(16'h02FF, 6'd8, 6'd8, 0, 66);
    check("model_s2_last", int'(mdl[63]), 913);
    check("s2_first", int'(got[0]), 458);
    check("s2_last", int'(got[63]), 913);
    run_block(16'h8000, 6'd0, 6'd0, 0, 66);
    check("s3_row0_end", int'(got[7]), 0);
    check("s3_row1", int'(got[8]), 64);
    check("s3_last", int'(got[63]), 448);
    run_block(16'h0707, 6'd56, 6'd56, 0, 66);
    check("s4_row7_first", int'(got[56]), 4095);
    check("s4_last", int'(got[63]), 4095);
    run_block(16'h0000, 6'd8, 6'd8, 2, 69);
    mism = 0;
    foreach (ref1[i]) if (i >= got.size() || got[i] != ref1[i]) mism++;
    check("stall_same_seq", mism, 0);
    run_block(16'h0000, 6'd8, 6'd8, 3, 66);
    tick();
    tick();
    check("start_while_busy_ignored", int'(BUSY), 0);
    run_block(16'h0000, 6'd8, 6'd8, 4, -1);
    run_block(16'h0000, 6'd8, 6'd8, 0, 66);
    mism = 0;
    foreach (ref1[i]) if (i >= got.size() || got[i] != ref1[i]) mism++;
    check("rerun_after_abort", mism, 0);
    for (int k = 0; k < 12; k++)
      run_block(16'($urandom), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), k % 3 == 0 ? 0 : 1, k % 3 == 0 ? 66 : -1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
